oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/gb_bus_pkg.sv | 15 +
 rtl/rrmmap.sv | 30 +++
 rtl/oam_dma.sv | 96 +++++++++
 tb/tb_oam_dma.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gb_bus_pkg.sv
// Shared bus map for the Game Boy style system bus.
// It holds the fixed register and OAM addresses, the OAM size and the DMA sequencer states.
package gb_bus_pkg;

  localparam logic [15:0] DMA_SRC_ADDR  = 16'hff46;
  localparam logic [15:0] OAM_BASE_ADDR = 16'hfe00;
  localparam int unsigned OAM_BYTES     = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } dma_state_e;

endpackage : gb_bus_pkg

// File: rtl/rrmmap.sv
// Single 8-bit CPU-visible register at a fixed bus address.
// Reads have one cycle of latency, and the read data is zero when the register is not selected.
module rrmmap #(
  parameter logic [15:0] ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  input  logic        load,
  input  logic        store,
  output logic [7:0]  outdata,
  output logic [7:0]  value,
  output logic        hit_store
);

  assign hit_store = store && (address == ADDR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value   <= 8'h00;
      outdata <= 8'h00;
    end else begin
      if (hit_store) value <= indata;
      outdata <= (load && (address == ADDR)) ? value : 8'h00;
    end
  end

endmodule : rrmmap

// File: rtl/oam_dma.sv
// OAM DMA engine that copies LENGTH bytes from {src,8'h00} into OAM.
// Each byte uses a read/write bus pair.
module oam_dma
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] REG_ADDR = DMA_SRC_ADDR,
  parameter logic [15:0] OAM_BASE = OAM_BASE_ADDR,
  parameter int unsigned LENGTH   = OAM_BYTES
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  input  logic [7:0]  dma_indata,
  output logic [7:0]  dma_outdata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        busy
);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src;
  logic       start;
  logic [8:0] idx_inc;

  rrmmap #(.ADDR(REG_ADDR)) u_src_reg (
    .clk       (clockgb),
    .rst_n     (resetn),
    .address   (address),
    .indata    (indata),
    .load      (load),
    .store     (store),
    .outdata   (outdata),
    .value     (src),
    .hit_store (start)
  );

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Widen by one bit so the end-of-transfer compare cannot wrap.
  assign idx_inc = {1'b0, idx_q} + 9'd1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dma_address = 16'h0000;
    dma_outdata = 8'h00;
    dma_load    = 1'b0;
    dma_store   = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      READ: begin
        busy        = 1'b1;
        dma_address = {src, idx_q};
        dma_load    = 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        dma_address = OAM_BASE + {8'h00, idx_q};
        dma_outdata = dma_indata;
        dma_store   = 1'b1;
        if (32'(idx_inc) < LENGTH) begin
          state_d = READ;
          idx_d   = idx_inc[7:0];
        end else begin
          state_d = IDLE;
          idx_d   = 8'h00;
        end
      end
      default: ;
    endcase

    // A new source write restarts the copy from byte 0, whatever the current state.
    if (start) begin
      state_d = READ;
      idx_d   = 8'h00;
    end
  end

endmodule : oam_dma

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma.
// It models the source memory as a pure function of address and captures the OAM writes.
module tb_oam_dma;

  logic        clockgb = 1'b0;
  logic        resetn  = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  indata  = 8'h00;
  logic [7:0]  outdata;
  logic        load    = 1'b0;
  logic        store   = 1'b0;
  logic [15:0] dma_address;
  logic [7:0]  dma_indata = 8'h00;
  logic [7:0]  dma_outdata;
  logic        dma_load;
  logic        dma_store;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int store_cnt = 0;
  logic [15:0] last_store_addr = 16'h0000;
  logic [7:0]  oam [160];

  oam_dma dut (
    .clockgb     (clockgb),
    .resetn      (resetn),
    .address     (address),
    .indata      (indata),
    .outdata     (outdata),
    .load        (load),
    .store       (store),
    .dma_address (dma_address),
    .dma_indata  (dma_indata),
    .dma_outdata (dma_outdata),
    .dma_load    (dma_load),
    .dma_store   (dma_store),
    .busy        (busy)
  );

  always #5 clockgb = ~clockgb;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[15:8] ^ (a[7:0] * 8'd5) ^ 8'h5a;
  endfunction

  // Source memory and OAM model: one-cycle read latency, plus capture of the writes.
  always @(posedge clockgb) begin
    dma_indata <= dma_load ? mem_byte(dma_address) : 8'h00;
    if (resetn && dma_store) begin
      store_cnt++;
      last_store_addr <= dma_address;
      if (dma_address >= 16'hfe00 && dma_address <= 16'hfe9f)
        oam[dma_address - 16'hfe00] <= dma_outdata;
    end
    if (resetn) begin
      assert (!(dma_load && dma_store)) else viol++;
      assert (!dma_store || (dma_address >= 16'hfe00 && dma_address <= 16'hfe9f)) else viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start this task at a negedge. It drives the write and returns one negedge later.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    address = a; indata = d; store = 1'b1;
    @(negedge clockgb);
    store = 1'b0; address = 16'h0000; indata = 8'h00;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) oam[i] = 8'h00;
  endtask

  // Call this at the first busy negedge. It checks every READ/WRITE pair, the end of busy and the OAM contents.
  task automatic run_transfer(input string tag, input logic [7:0] s);
    int bad;
    int i;
    logic [15:0] ra;
    bad = 0;
    for (int c = 0; c < 320; c++) begin
      i  = c / 2;
      ra = {s, i[7:0]};
      if (c % 2 == 0) begin
        if (!(busy && dma_load && !dma_store && dma_address == ra)) bad++;
      end else begin
        if (!(busy && dma_store && !dma_load && dma_address == 16'hfe00 + 16'(i)
              && dma_outdata == mem_byte(ra))) bad++;
      end
      @(negedge clockgb);
    end
    check({tag, "_seq"}, bad, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_last_store"}, last_store_addr, 16'hfe9f);
    bad = 0;
    for (int k = 0; k < 160; k++)
      if (oam[k] !== mem_byte({s, 8'(k)})) bad++;
    check({tag, "_oam"}, bad, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && busy; c++) @(negedge clockgb);
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int sc;
    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_dma", {dma_load, dma_store, dma_address, dma_outdata}, 0);
    check("rst_outdata", outdata, 0);
    @(negedge clockgb); @(negedge clockgb);
    resetn = 1'b1;
    @(negedge clockgb);
    check("idle_after_rst", busy, 0);

    // CPU readback: data appears one cycle after the load, then returns to zero
    cpu_write(16'hff46, 8'h80);
    address = 16'hff46; load = 1'b1;
    @(negedge clockgb);
    check("read_80", outdata, 8'h80);
    load = 1'b0;
    @(negedge clockgb);
    check("read_80_after", outdata, 8'h00);
    address = 16'hff47; load = 1'b1;
    @(negedge clockgb);
    check("read_other_addr", outdata, 8'h00);
    load = 1'b0; address = 16'h0000;
    wait_idle(400);

    // Full transfer from c100
    clear_oam();
    cpu_write(16'hff46, 8'hc1);
    check("busy_rise", busy, 1);
    run_transfer("c1", 8'hc1);

    // Source ff: low address byte must not carry into the page
    clear_oam();
    cpu_write(16'hff46, 8'hff);
    run_transfer("ff", 8'hff);

    // Restart at busy cycle 51
    clear_oam();
    cpu_write(16'hff46, 8'hc0);
    repeat (50) @(negedge clockgb);
    check("busy_mid_c0", busy, 1);
    cpu_write(16'hff46, 8'hd0);
    run_transfer("restart_d0", 8'hd0);

    // Reset at busy cycle 100
    cpu_write(16'hff46, 8'hc1);
    repeat (99) @(negedge clockgb);
    check("busy_before_rst", busy, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dma", {dma_load, dma_store, dma_address, dma_outdata}, 0);
    check("mid_rst_outdata", outdata, 0);
    @(negedge clockgb);
    resetn = 1'b1;
    sc = store_cnt;
    repeat (20) @(negedge clockgb);
    check("no_resume_stores", store_cnt, sc);
    check("no_resume_busy", busy, 0);
    address = 16'hff46; load = 1'b1;
    @(negedge clockgb);
    check("src_cleared", outdata, 8'h00);
    load = 1'b0; address = 16'h0000;
    @(negedge clockgb);

    check("bus_protocol_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_oam_dma
